// File: rtl/pc_sequencer_pkg.sv
// Shared types for the program-counter sequencer.
// Optional feature macro used by the interface and top: PCSEQ_LINK_EN.
package pc_seq_pkg;
  localparam int LUT_AW = 4;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } pcseq_state_t;
endpackage

// File: rtl/pc_sequencer_if.sv
// Decoder / fetch / LUT signal bundle between pc_sequencer (master) and its surroundings (slave).
// PCSEQ_LINK_EN adds the link_en / ret_en decoder strobes.
interface pc_sequencer_if #(
  parameter int D     = 12,
  parameter int CNT_W = 16
);
  import pc_seq_pkg::*;

  logic              start;
  logic              stall;
  logic              halt;
  logic              branch_en;
  logic [LUT_AW-1:0] branch_idx;
  logic [LUT_AW-1:0] lut_addr;
  logic [D-1:0]      lut_target;
  logic [D-1:0]      prog_ctr;
  logic              fetch_valid;
  logic              done;
  logic [CNT_W-1:0]  retired;
`ifdef PCSEQ_LINK_EN
  logic              link_en;
  logic              ret_en;
`endif

  modport master (
    input  start, stall, halt, branch_en, branch_idx, lut_target,
`ifdef PCSEQ_LINK_EN
    input  link_en, ret_en,
`endif
    output lut_addr, prog_ctr, fetch_valid, done, retired
  );

  modport slave (
    output start, stall, halt, branch_en, branch_idx, lut_target,
`ifdef PCSEQ_LINK_EN
    output link_en, ret_en,
`endif
    input  lut_addr, prog_ctr, fetch_valid, done, retired
  );
endinterface

// File: rtl/pc_sequencer.sv
// Program counter and fetch sequencer with start/done handshake and saturating retire count.
// PCSEQ_LINK_EN adds a link register with link_en (call) and ret_en (return).
//
// state | meaning
// IDLE  | after reset, waiting for a start rising edge
// RUN   | fetching; PC advances, branches or holds on stall
// DONE  | halt retired; waiting for a start rising edge to relaunch
module pc_sequencer
  import pc_seq_pkg::*;
#(
  parameter int           D        = 12,
  parameter logic [D-1:0] START_PC = '0,
  parameter int           CNT_W    = 16
) (
  input  logic          clk,
  input  logic          reset_n,
  pc_sequencer_if.master bus
);

  pcseq_state_t     state_q, state_nxt;
  logic [D-1:0]     pc_q, pc_nxt;
  logic [CNT_W-1:0] ret_q, ret_nxt, ret_inc;
  logic             start_q;
  logic             start_rise;
`ifdef PCSEQ_LINK_EN
  logic [D-1:0]     link_q, link_nxt;
`endif

  assign start_rise = bus.start & ~start_q;
  assign ret_inc    = (&ret_q) ? ret_q : ret_q + CNT_W'(1);

  always_comb begin
    state_nxt = state_q;
    pc_nxt    = pc_q;
    ret_nxt   = ret_q;
`ifdef PCSEQ_LINK_EN
    link_nxt  = link_q;
`endif
    case (state_q)
      IDLE, DONE: begin
        if (start_rise) begin
          state_nxt = RUN;
          pc_nxt    = START_PC;
          ret_nxt   = '0;
        end
      end
      RUN: begin
        if (!bus.stall) begin
          ret_nxt = ret_inc;
          if (bus.halt) begin
            state_nxt = DONE;
          end
`ifdef PCSEQ_LINK_EN
          else if (bus.ret_en) begin
            pc_nxt = link_q;
          end
          else if (bus.link_en) begin
            pc_nxt   = pc_q + bus.lut_target;
            link_nxt = pc_q + D'(1);
          end
`endif
          else if (bus.branch_en) begin
            pc_nxt = pc_q + bus.lut_target;
          end
          else begin
            pc_nxt = pc_q + D'(1);
          end
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  // start_q resets high so a start level already present at reset release is not seen as an edge.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= IDLE;
      pc_q    <= START_PC;
      ret_q   <= '0;
      start_q <= 1'b1;
    end else begin
      state_q <= state_nxt;
      pc_q    <= pc_nxt;
      ret_q   <= ret_nxt;
      start_q <= bus.start;
    end
  end

`ifdef PCSEQ_LINK_EN
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) link_q <= START_PC;
    else          link_q <= link_nxt;
  end
`endif

  assign bus.lut_addr    = bus.branch_idx;
  assign bus.prog_ctr    = pc_q;
  assign bus.retired     = ret_q;
  assign bus.done        = (state_q == DONE);
  assign bus.fetch_valid = (state_q == RUN) && !bus.stall;

endmodule
